// File: rtl/spi_slave.sv
// SPI slave clocked entirely by i_clk: SCK, CS and MOSI are oversampled through
// synchronizers, and SCK edges are turned into sample/shift strobes for the byte engine.
module spi_slave #(
    parameter int SPI_MODE = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_oe,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic       sclkMeta_q, sclkSync_q, sclkHist_q;
    logic       csMeta_q, csSync_q, csHist_q;
    logic       mosiMeta_q, mosiSync_q;

    logic [0:0] state_q, state_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [6:0] rxShift_q, rxShift_d;
    logic [7:0] rxData_q, rxData_d;
    logic       rxValid_q, rxValid_d;
    logic [7:0] txShift_q, txShift_d;
    logic       loadPending_q, loadPending_d;
    logic [7:0] holdData_q, holdData_d;
    logic       holdFull_q, holdFull_d;

    logic       sclkRise, sclkFall, leadEdge, trailEdge;
    logic       sampleEv, shiftEv;
    logic       csFall, csRise;
    logic       txLoad, txCapture;
    logic [7:0] rxNext;

    // Reset values match the bus idle levels so leaving reset never fakes an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclkMeta_q <= CPOL;
            sclkSync_q <= CPOL;
            sclkHist_q <= CPOL;
            csMeta_q   <= 1'b1;
            csSync_q   <= 1'b1;
            csHist_q   <= 1'b1;
            mosiMeta_q <= 1'b0;
            mosiSync_q <= 1'b0;
        end else begin
            sclkMeta_q <= i_sclk;
            sclkSync_q <= sclkMeta_q;
            sclkHist_q <= sclkSync_q;
            csMeta_q   <= i_cs_n;
            csSync_q   <= csMeta_q;
            csHist_q   <= csSync_q;
            mosiMeta_q <= i_mosi;
            mosiSync_q <= mosiMeta_q;
        end
    end

    assign sclkRise  = sclkSync_q & ~sclkHist_q;
    assign sclkFall  = ~sclkSync_q & sclkHist_q;
    assign leadEdge  = CPOL ? sclkFall : sclkRise;
    assign trailEdge = CPOL ? sclkRise : sclkFall;
    assign sampleEv  = CPHA ? trailEdge : leadEdge;
    assign shiftEv   = CPHA ? leadEdge : trailEdge;
    assign csFall    = ~csSync_q & csHist_q;
    assign csRise    = csSync_q & ~csHist_q;
    assign rxNext    = {rxShift_q, mosiSync_q};

    // loadPending marks that the next shift event starts a new byte and must
    // reload the TX shifter instead of shifting it.
    always_comb begin
        state_d       = state_q;
        bitCnt_d      = bitCnt_q;
        rxShift_d     = rxShift_q;
        rxData_d      = rxData_q;
        rxValid_d     = 1'b0;
        txShift_d     = txShift_q;
        loadPending_d = loadPending_q;
        txLoad        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (csFall) begin
                    state_d       = ST_ACTIVE;
                    bitCnt_d      = 3'd7;
                    rxShift_d     = 7'd0;
                    loadPending_d = CPHA;
                    txLoad        = ~CPHA;
                end
            end
            ST_ACTIVE: begin
                if (csRise) begin
                    state_d       = ST_IDLE;
                    bitCnt_d      = 3'd7;
                    rxShift_d     = 7'd0;
                    loadPending_d = 1'b0;
                end else begin
                    if (sampleEv) begin
                        rxShift_d = rxNext[6:0];
                        if (bitCnt_q == 3'd0) begin
                            rxData_d      = rxNext;
                            rxValid_d     = 1'b1;
                            bitCnt_d      = 3'd7;
                            loadPending_d = 1'b1;
                        end else begin
                            bitCnt_d = bitCnt_q - 3'd1;
                        end
                    end
                    if (shiftEv) begin
                        if (loadPending_q) begin
                            txLoad        = 1'b1;
                            loadPending_d = 1'b0;
                        end else begin
                            txShift_d = {txShift_q[6:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (txLoad) begin
            txShift_d = holdFull_q ? holdData_q : 8'h00;
        end
    end

    // A capture in the same cycle as a load refills the buffer after the old byte leaves.
    always_comb begin
        txCapture  = i_tx_valid & ~holdFull_q;
        holdData_d = txCapture ? i_tx_data : holdData_q;
        holdFull_d = holdFull_q;
        if (txCapture) begin
            holdFull_d = 1'b1;
        end else if (txLoad) begin
            holdFull_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            bitCnt_q      <= 3'd7;
            rxShift_q     <= 7'd0;
            rxData_q      <= 8'h00;
            rxValid_q     <= 1'b0;
            txShift_q     <= 8'h00;
            loadPending_q <= 1'b0;
            holdData_q    <= 8'h00;
            holdFull_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bitCnt_q      <= bitCnt_d;
            rxShift_q     <= rxShift_d;
            rxData_q      <= rxData_d;
            rxValid_q     <= rxValid_d;
            txShift_q     <= txShift_d;
            loadPending_q <= loadPending_d;
            holdData_q    <= holdData_d;
            holdFull_q    <= holdFull_d;
        end
    end

    assign o_miso_oe  = (state_q == ST_ACTIVE);
    assign o_miso     = (state_q == ST_ACTIVE) & txShift_q[7];
    assign o_tx_ready = ~holdFull_q;
    assign o_rx_data  = rxData_q;
    assign o_rx_valid = rxValid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a bit-banged master, and a
// byte-level model (master gets the byte queued for each slot or 00, slave gets MOSI).
module tb_spi_slave;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sclk, csN, mosi, txValid;
    logic [3:0] miso, misoOe, txReady, rxValid;
    logic [7:0] txData [4];
    logic [7:0] rxData [4];

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] mosiBytes [4];
    logic [7:0] slvTx [4];
    bit         provide [4];
    logic [7:0] got [4];

    logic [7:0] rxSeen [$];
    int         rxWide = 0;
    logic [3:0] prevValid = 4'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gDut
        spi_slave #(.SPI_MODE(g)) uDut (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_sclk    (sclk[g]),
            .i_cs_n    (csN[g]),
            .i_mosi    (mosi[g]),
            .o_miso    (miso[g]),
            .o_miso_oe (misoOe[g]),
            .i_tx_data (txData[g]),
            .i_tx_valid(txValid[g]),
            .o_tx_ready(txReady[g]),
            .o_rx_data (rxData[g]),
            .o_rx_valid(rxValid[g])
        );
    end

    // Records every received byte and flags any o_rx_valid lasting over one cycle.
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (rxValid[g]) begin
                rxSeen.push_back(rxData[g]);
                if (prevValid[g]) rxWide++;
            end
        end
        prevValid = rxValid;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic halfWait();
        repeat (HALF) @(posedge clk);
        #2;
    endtask

    task automatic pushByte(input int m, input logic [7:0] d);
        int guard;
        guard = 0;
        while (!txReady[m] && guard < 200) begin
            @(posedge clk);
            #2;
            guard++;
        end
        checkOutput("txReadyBeforePush", 32'(txReady[m]), 32'd1);
        txData[m]  = d;
        txValid[m] = 1'b1;
        @(posedge clk);
        #2;
        txValid[m] = 1'b0;
        checkOutput("txReadyAfterPush", 32'(txReady[m]), 32'd0);
    endtask

    // Master side: drives nb bytes, stops after stopBits bits, optionally resets instead of deselecting.
    task automatic spiFrame(input int m, input int nb, input int stopBits, input bit doReset);
        bit cpol, cpha, aborted;
        int bitsDone;
        cpol = (m >= 2);
        cpha = (m == 1) || (m == 3);
        aborted = 1'b0;
        bitsDone = 0;
        csN[m] = 1'b0;
        halfWait();
        checkOutput("misoOeActive", 32'(misoOe[m]), 32'd1);
        for (int b = 0; b < nb; b++) begin
            for (int i = 7; i >= 0; i--) begin
                if (!aborted) begin
                    if (i == 3 && b + 1 < nb && provide[b + 1]) pushByte(m, slvTx[b + 1]);
                    if (!cpha) begin
                        mosi[m] = mosiBytes[b][i];
                        halfWait();
                        got[b][i] = miso[m];
                        sclk[m] = ~cpol;
                        halfWait();
                        sclk[m] = cpol;
                    end else begin
                        sclk[m] = ~cpol;
                        mosi[m] = mosiBytes[b][i];
                        halfWait();
                        got[b][i] = miso[m];
                        sclk[m] = cpol;
                        halfWait();
                    end
                    bitsDone++;
                    if (bitsDone == stopBits) aborted = 1'b1;
                end
            end
        end
        halfWait();
        if (doReset) begin
            rst = 1'b1;
            csN[m] = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("rstMisoOe", 32'(misoOe[m]), 32'd0);
            checkOutput("rstMiso", 32'(miso[m]), 32'd0);
            checkOutput("rstRxValid", 32'(rxValid[m]), 32'd0);
            checkOutput("rstRxData", 32'(rxData[m]), 32'h00);
            checkOutput("rstTxReady", 32'(txReady[m]), 32'd1);
            #1;
            rst = 1'b0;
        end else begin
            csN[m] = 1'b1;
        end
        repeat (2 * HALF) @(posedge clk);
        #2;
        checkOutput("misoOeIdle", 32'(misoOe[m]), 32'd0);
    endtask

    // Full frame of nb bytes, then compare both directions against the byte-level model.
    task automatic applyStimulus(input int m, input int nb);
        logic [7:0] seen;
        rxSeen.delete();
        if (provide[0]) pushByte(m, slvTx[0]);
        spiFrame(m, nb, nb * 8, 1'b0);
        checkOutput("rxCount", 32'(rxSeen.size()), 32'(nb));
        for (int b = 0; b < nb; b++) begin
            seen = (b < rxSeen.size()) ? rxSeen[b] : 8'hxx;
            checkOutput("rxByte", 32'(seen), 32'(mosiBytes[b]));
            checkOutput("misoByte", 32'(got[b]), 32'(provide[b] ? slvTx[b] : 8'h00));
        end
        checkOutput("txReadyAfterFrame", 32'(txReady[m]), 32'd1);
    endtask

    initial begin
        int m, nb;
        sclk = 4'b1100;
        csN = 4'b1111;
        mosi = 4'b0000;
        txValid = 4'b0000;
        for (int g = 0; g < 4; g++) txData[g] = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            checkOutput("resetMisoOe", 32'(misoOe[g]), 32'd0);
            checkOutput("resetMiso", 32'(miso[g]), 32'd0);
            checkOutput("resetTxReady", 32'(txReady[g]), 32'd1);
            checkOutput("resetRxValid", 32'(rxValid[g]), 32'd0);
            checkOutput("resetRxData", 32'(rxData[g]), 32'h00);
        end
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        $display("[TB] mode 0 single byte with preload");
        mosiBytes[0] = 8'h3C; slvTx[0] = 8'hA5; provide[0] = 1'b1;
        applyStimulus(0, 1);

        $display("[TB] mode 3 single byte with preload");
        mosiBytes[0] = 8'h81; slvTx[0] = 8'hF0; provide[0] = 1'b1;
        applyStimulus(3, 1);

        $display("[TB] mode 1 two bytes under one select");
        mosiBytes[0] = 8'h6E; mosiBytes[1] = 8'hB2;
        slvTx[0] = 8'h11; slvTx[1] = 8'h22; provide[0] = 1'b1; provide[1] = 1'b1;
        applyStimulus(1, 2);

        $display("[TB] mode 2 underrun");
        mosiBytes[0] = 8'h55; provide[0] = 1'b0;
        applyStimulus(2, 1);

        $display("[TB] mode 0 deselect mid-byte then full frame");
        rxSeen.delete();
        mosiBytes[0] = 8'hFF; provide[0] = 1'b0;
        spiFrame(0, 1, 5, 1'b0);
        checkOutput("abortNoRxValid", 32'(rxSeen.size()), 32'd0);
        mosiBytes[0] = 8'hC3;
        applyStimulus(0, 1);

        $display("[TB] mode 0 reset mid-frame");
        rxSeen.delete();
        mosiBytes[0] = 8'h9A; mosiBytes[1] = 8'h47;
        slvTx[0] = 8'h5A; slvTx[1] = 8'hE1; provide[0] = 1'b1; provide[1] = 1'b1;
        pushByte(0, slvTx[0]);
        spiFrame(0, 2, 5, 1'b1);
        checkOutput("resetAbortNoRx", 32'(rxSeen.size()), 32'd0);
        mosiBytes[0] = 8'h2D; slvTx[0] = 8'h7B; provide[0] = 1'b1;
        applyStimulus(0, 1);

        $display("[TB] randomized frames");
        for (int t = 0; t < 12; t++) begin
            m = $urandom_range(0, 3);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < 4; b++) begin
                mosiBytes[b] = 8'($urandom);
                slvTx[b] = 8'($urandom);
                provide[b] = 1'($urandom_range(0, 1));
            end
            applyStimulus(m, nb);
        end

        checkOutput("rxValidPulseWidth", 32'(rxWide), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SPI_MODE, default 0, meaning: SPI mode 0-3, where CPOL = mode 2 or 3 and CPHA = mode 1 or 3.
REQ-002 SHALL have port i_clk, input, 1 bit: system clock; all logic is on its rising edge, and this is the only clock.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_sclk, input, 1 bit: SPI clock from the master, asynchronous to i_clk.
REQ-005 SHALL have port i_cs_n, input, 1 bit: chip select, active-low, asynchronous.
REQ-006 SHALL have port i_mosi, input, 1 bit: serial data from the master.
REQ-007 SHALL have port o_miso, output, 1 bit: serial data to the master.
REQ-008 SHALL have port o_miso_oe, output, 1 bit: MISO output enable, high while selected.
REQ-009 SHALL have port i_tx_data, input, 8 bits: next byte to transmit.
REQ-010 SHALL have port i_tx_valid, input, 1 bit: i_tx_data is valid.
REQ-011 SHALL have port o_tx_ready, output, 1 bit: TX holding buffer is empty.
REQ-012 SHALL have port o_rx_data, output, 8 bits: last complete received byte.
REQ-013 SHALL have port o_rx_valid, output, 1 bit: one-cycle pulse when o_rx_data updates.

Function
REQ-014 SHALL pass i_sclk, i_cs_n and i_mosi each through a 2-flop synchronizer, plus one history flop for edge detection.
- i_clk SHALL be at least 8x the SCK frequency.
REQ-015 SHALL detect edges on the synchronized SCK.
- Leading edge: the transition away from CPOL.
- Trailing edge: the transition back to CPOL.
REQ-016 SHALL implement an FSM with states IDLE, ACTIVE.
- IDLE -> ACTIVE on the synchronized CS falling edge.
- ACTIVE -> IDLE on the synchronized CS rising edge, from any bit position.
REQ-017 SHALL define the sample event as the leading edge if CPHA=0, else the trailing edge.
REQ-018 SHALL define the shift event as the trailing edge if CPHA=0, else the leading edge.
REQ-019 SHALL, in ACTIVE on each sample event, shift the synchronized MOSI into the RX shift register MSB-first and decrement a 3-bit bit counter that starts at 7.
REQ-020 SHALL, on the sample event with counter = 0:
- write the completed byte to o_rx_data;
- pulse o_rx_valid high for exactly one i_clk;
- wrap the counter to 7 (back-to-back bytes under one CS).
REQ-021 SHALL load the TX shift register from the holding buffer at each byte start:
- CPHA=0: on entry to ACTIVE and on the shift event that follows the 8th sample of a byte.
- CPHA=1: on the first shift event of each byte.
REQ-022 SHALL load 8'h00 into the TX shift register if the holding buffer is empty at a load.
REQ-023 SHALL drive o_miso from the TX shift register MSB and left-shift it on every shift event that is not a load.
REQ-024 SHALL assert o_tx_ready when the holding buffer is empty.
- i_tx_valid && o_tx_ready captures i_tx_data and drops o_tx_ready on the next cycle.
- A load empties the buffer, and o_tx_ready rises the cycle after the load.
- i_tx_valid while o_tx_ready=0 is ignored.
REQ-025 SHALL, when a load and a capture occur in the same cycle, load the old buffer contents and capture the new byte, leaving o_tx_ready=0.
REQ-026 SHALL hold o_miso_oe = 1 in ACTIVE and 0 in IDLE.
- o_miso SHALL be 0 in IDLE.
REQ-027 SHALL, when CS rises mid-byte, discard the partial RX byte without asserting o_rx_valid and reset the counter to 7.
- The holding buffer SHALL be retained.
REQ-028 SHALL ignore SCK edges while in IDLE.

Reset
REQ-029 SHALL, on i_rst=1 at a clock edge, set:
- FSM = IDLE, counter = 7, RX and TX shift registers = 0;
- holding buffer empty, o_tx_ready = 1;
- o_rx_data = 8'h00, o_rx_valid = 0, o_miso = 0, o_miso_oe = 0;
- synchronizer flops to CS=1 and SCK=CPOL.
REQ-030 SHALL, when reset is applied mid-frame, abort the frame.
- After reset, no further SCK edges are honored until a new synchronized CS falling edge.

Verification
REQ-031 Mode 0: preload 8'hA5, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; o_rx_data=8'h3C with a single o_rx_valid pulse; o_tx_ready returns to 1.
REQ-032 Mode 3: preload 8'hF0, master sends 8'h81 -> master receives 8'hF0; o_rx_data=8'h81.
REQ-033 Mode 1, two bytes under one CS: preload 8'h11, then provide 8'h22 during byte 1 -> master receives 8'h11 then 8'h22; two o_rx_valid pulses.
REQ-034 Underrun: no preload, master sends 8'h55 -> master receives 8'h00; o_rx_data=8'h55.
REQ-035 CS rises after 5 SCK cycles -> no o_rx_valid; the next full frame of 8'hC3 yields o_rx_data=8'hC3.
REQ-036 i_rst asserted mid-frame -> all outputs at reset values the next cycle; o_tx_ready=1.
